// File: rtl/pipe_sched_pkg.sv
// rtl/pipe_sched_pkg.sv - shared state encoding and LFSR constants for the pipe scheduler
package pipe_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPACE  = 2'd1,
    ST_PIPE   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps x^8+x^6+x^5+x^4+1 expressed as register bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/pipe_sched_if.sv
// rtl/pipe_sched_if.sv - control and column-stream signals between game logic and pipe scheduler
interface pipe_sched_if #(
  parameter int ROWS = 8
);
  logic            start;
  logic            lose;
  logic            shift;
  logic [ROWS-1:0] col_pattern;
  logic            pipe_done;
  logic            running;

  modport master (
    output start, lose,
    input  shift, col_pattern, pipe_done, running
  );

  modport slave (
    input  start, lose,
    output shift, col_pattern, pipe_done, running
  );
endinterface

// File: rtl/pipe_lfsr.sv
// rtl/pipe_lfsr.sv - free-running 8-bit Fibonacci LFSR used to pick pipe gap positions
module pipe_lfsr
  import pipe_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - shift strobe and right-edge column generator for the pipe row shifters
// Build option: PIPE_SCHED_SPEEDUP_EN shortens the shift period every fourth pipe.
module pipe_scheduler
  import pipe_sched_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int SHIFT_PERIOD = 8,
  parameter int SPACE        = 3,
  parameter int PIPE_W       = 1,
  parameter int GAP_H        = 3,
  parameter int MIN_PERIOD   = 2
) (
  input logic         clk,
  input logic         reset,
  pipe_sched_if.slave sif
);

  localparam int PERIOD_MAX = (SHIFT_PERIOD > MIN_PERIOD) ? SHIFT_PERIOD : MIN_PERIOD;
  localparam int DIV_W      = $clog2(PERIOD_MAX + 1);
  localparam int COL_MAX    = (SPACE > PIPE_W) ? SPACE : PIPE_W;
  localparam int COL_W      = $clog2(COL_MAX + 1);
  localparam int GAP_W      = $clog2(ROWS + 1);
  localparam int GAP_MOD    = ROWS - GAP_H - 1;
  localparam logic [DIV_W-1:0] PERIOD_INIT = DIV_W'(PERIOD_MAX);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [ROWS-1:0]  pat_q, pat_d;

  logic [7:0]       lfsr;
  logic [DIV_W-1:0] period;
  logic [GAP_W-1:0] gap_new;
  logic [ROWS-1:0]  pipe_pat;
  logic             go, running, tick, shift, pipe_done;

  pipe_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .lfsr_o (lfsr)
  );

  // Gap rows are cleared; row 0 and the rows above the gap stay lit.
  always_comb begin
    gap_new = GAP_W'(1 + (int'(lfsr) % GAP_MOD));
    for (int r = 0; r < ROWS; r++) begin
      pipe_pat[r] = !((r >= int'(gap_new)) && (r < int'(gap_new) + GAP_H));
    end
  end

  always_comb begin
    running   = (state_q == ST_SPACE) || (state_q == ST_PIPE);
    go        = ((state_q == ST_IDLE) || (state_q == ST_FROZEN)) && sif.start && !sif.lose;
    tick      = (div_q == period - DIV_W'(1));
    shift     = tick && running && !sif.lose;
    pipe_done = shift && (state_q == ST_PIPE) && (col_q == COL_W'(PIPE_W - 1));
  end

`ifdef PIPE_SCHED_SPEEDUP_EN
  logic [DIV_W-1:0] period_q, period_d;
  logic [1:0]       pcnt_q, pcnt_d;

  always_comb begin
    period_d = period_q;
    pcnt_d   = pcnt_q;
    if (go) begin
      period_d = PERIOD_INIT;
      pcnt_d   = 2'd0;
    end else if (pipe_done) begin
      pcnt_d = pcnt_q + 2'd1;
      if ((pcnt_q == 2'd3) && (period_q > DIV_W'(MIN_PERIOD))) begin
        period_d = period_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q <= PERIOD_INIT;
      pcnt_q   <= 2'd0;
    end else begin
      period_q <= period_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign period = period_q;
`else
  assign period = PERIOD_INIT;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    col_d   = col_q;
    gap_d   = gap_q;
    pat_d   = pat_q;
    case (state_q)
      ST_IDLE, ST_FROZEN: begin
        if (go) begin
          state_d = ST_SPACE;
          div_d   = '0;
          col_d   = '0;
          pat_d   = '0;
        end
      end
      ST_SPACE, ST_PIPE: begin
        if (sif.lose) begin
          state_d = ST_FROZEN;
        end else begin
          div_d = tick ? '0 : div_q + DIV_W'(1);
          if (tick && (state_q == ST_SPACE)) begin
            if (col_q == COL_W'(SPACE - 1)) begin
              state_d = ST_PIPE;
              col_d   = '0;
              gap_d   = gap_new;
              pat_d   = pipe_pat;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (tick) begin
            if (col_q == COL_W'(PIPE_W - 1)) begin
              state_d = ST_SPACE;
              col_d   = '0;
              pat_d   = '0;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      col_q   <= '0;
      gap_q   <= GAP_W'(1);
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      gap_q   <= gap_d;
      pat_q   <= pat_d;
    end
  end

  assign sif.shift       = shift;
  assign sif.col_pattern = pat_q;
  assign sif.pipe_done   = pipe_done;
  assign sif.running     = running;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - directed self-checking bench for pipe_scheduler
module tb_pipe_scheduler;

  localparam int SP     = 4;
  localparam int MIN_P  = 2;
  localparam int CYC_COLS = 4;

  logic clk;
  logic reset;

  pipe_sched_if #(.ROWS(8)) sif ();

  pipe_scheduler #(
    .ROWS(8), .SHIFT_PERIOD(SP), .SPACE(3), .PIPE_W(1), .GAP_H(3), .MIN_PERIOD(MIN_P)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc, k, pipes, exp_period, guard;
  bit         m_run;
  logic [7:0] exp_pat, frozen_col, m_lfsr;

  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat_of(input logic [7:0] l);
    int g;
    logic [7:0] p;
    g = 1 + (int'(l) % 4);
    for (int r = 0; r < 8; r++) p[r] = !((r >= g) && (r <= g + 2));
    return p;
  endfunction

  function automatic bit legal(input logic [7:0] c);
    return (c == 8'hF1) || (c == 8'hE3) || (c == 8'hC7) || (c == 8'h8F);
  endfunction

  task automatic do_start();
    sif.start = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
    m_run = 1'b1;
    cyc = 0; k = 0; pipes = 0; exp_period = SP;
  endtask

  task automatic step();
    @(negedge clk);
    if (m_run) begin
      cyc++;
      check("shift", sif.shift, cyc == exp_period);
      check("running", sif.running, 1);
      if (sif.shift) begin
        k++;
        if (k % CYC_COLS == 0) begin
          check("pipe_col", sif.col_pattern, exp_pat);
          check("pipe_col_legal", legal(sif.col_pattern), 1);
          check("pipe_done", sif.pipe_done, 1);
          pipes++;
`ifdef PIPE_SCHED_SPEEDUP_EN
          if ((pipes % 4 == 0) && (exp_period > MIN_P)) exp_period--;
`endif
        end else begin
          check("space_col", sif.col_pattern, 0);
          check("space_done", sif.pipe_done, 0);
        end
        if (k % CYC_COLS == 3) exp_pat = pat_of(m_lfsr);
        cyc = 0;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; sif.start = 1'b0; sif.lose = 1'b0; m_run = 1'b0;
    cyc = 0; k = 0; pipes = 0; exp_period = SP; exp_pat = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", {sif.shift, sif.pipe_done, sif.running, sif.col_pattern}, 0);
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_outs", {sif.shift, sif.pipe_done, sif.running, sif.col_pattern}, 0);
    end

    do_start();
    guard = 0;
    while (pipes < 50 && guard < 3000) begin step(); guard++; end
    check("pipes_seen", pipes >= 50, 1);

    guard = 0;
    while (!((k % CYC_COLS == 3) && (cyc == exp_period - 1)) && guard < 200) begin
      step(); guard++;
    end
    check("lose_sync", guard < 200, 1);
    @(posedge clk);
    #1 sif.lose = 1'b1;
    @(negedge clk);
    check("lose_shift", sif.shift, 0);
    check("lose_done", sif.pipe_done, 0);
    check("lose_col", sif.col_pattern, exp_pat);
    frozen_col = sif.col_pattern;
    @(posedge clk);
    #1 sif.lose = 1'b0;
    m_run = 1'b0;
    @(negedge clk);
    check("frozen_running", sif.running, 0);
    repeat (20) begin
      @(negedge clk);
      check("frozen_hold", {sif.shift, sif.running, sif.pipe_done, sif.col_pattern},
            {3'b000, frozen_col});
    end

    sif.start = 1'b1; sif.lose = 1'b1;
    @(posedge clk);
    #1 begin sif.start = 1'b0; sif.lose = 1'b0; end
    @(negedge clk);
    check("start_lose_stay", sif.running, 0);

    do_start();
    guard = 0;
    while (!(k == 7 && cyc == 1) && guard < 200) begin step(); guard++; end
    check("restart_sync", guard < 200, 1);
    check("restart_in_pipe", sif.col_pattern, exp_pat);
    #2 reset = 1'b0;
    #1;
    check("async_rst_running", sif.running, 0);
    check("async_rst_col", sif.col_pattern, 0);
    check("async_rst_shift", {sif.shift, sif.pipe_done}, 0);
    m_run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_idle", {sif.shift, sif.pipe_done, sif.running, sif.col_pattern}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
Controller that sequences the per-row green pipe shifters of the flappy-bird display. It generates the shift strobe (drives every row's `cycle`) and the column pattern injected at the right edge (one bit per row, drives each row's `lastColPattern`). Columns alternate between empty spacing and pipe columns; each pipe has a pseudo-random gap. Sits between the game FSM (start/lose) and the row shifter array.

Parameters:
ROWS, 8, number of display rows (width of col_pattern)
SHIFT_PERIOD, 8, clk cycles between shift strobes (top overrides for real speed)
SPACE, 3, empty columns emitted before each pipe
PIPE_W, 1, columns per pipe
GAP_H, 3, rows in each gap; requires ROWS-GAP_H-1 >= 1
MIN_PERIOD, 2, floor on shift period (used only with speed-up feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level/pulse; starts or restarts scrolling from IDLE or FROZEN
lose  in  1  game-over indication from collision logic
shift  out  1  one-clk strobe; row shifters advance on the edge ending this cycle
col_pattern  out  ROWS  column injected on the shift edge; bit r feeds row r (1 = pipe lit)
pipe_done  out  1  one-clk pulse coincident with the shift that consumes a pipe's last column
running  out  1  high in SPACE/PIPE states

Behaviour:
- Reset (reset==0, async): state=IDLE, div_cnt=0, col_cnt=0, gap_pos=1, lfsr=8'hA5; shift=0, col_pattern=0, pipe_done=0, running=0.
- States: IDLE, SPACE, PIPE, FROZEN.
- IDLE/FROZEN: start==1 -> SPACE. On that transition div_cnt=0, col_cnt=0, col_pattern=0. No shift while in IDLE or FROZEN. col_pattern holds its value in FROZEN.
- Divider: in SPACE/PIPE, div_cnt increments each clk and wraps at period-1.
- tick = (div_cnt==period-1). shift = tick & running & ~lose (combinational gating).
  - First shift occurs in the SHIFT_PERIOD-th cycle after entering SPACE.
  - Subsequent shifts occur every period cycles.
- col_pattern is registered. It presents the next column and changes only on an edge where shift==1, so the consumer samples a stable value.
- SPACE: col_pattern=0.
  - Each shift increments col_cnt.
  - On the shift consuming column SPACE-1: go to PIPE, col_cnt=0, latch gap_pos, load the pipe pattern.
- PIPE: col_pattern bit r = 0 for gap_pos <= r <= gap_pos+GAP_H-1; all other bits = 1.
  - Each shift increments col_cnt.
  - On the shift consuming column PIPE_W-1: pipe_done=1 for that cycle, go to SPACE, col_cnt=0, col_pattern=0.
- Gap selection: gap_pos = 1 + (lfsr mod (ROWS-GAP_H-1)), sampled when entering PIPE.
  - lfsr is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - lfsr free-runs every clk in all states except reset, so gap position depends on player start timing.
- lose: checked in SPACE/PIPE. If lose==1, go to FROZEN on the next edge.
  - No shift in any cycle with lose==1, even if tick==1.
  - pipe_done is suppressed in that cycle.
- Simultaneous start & lose in IDLE/FROZEN: lose wins; stay put.
- Reset mid-operation: immediate clear to reset values, independent of clk.

Optional Feature:
Macro: PIPE_SCHED_SPEEDUP_EN.
- Defined: a 2-bit pipe counter increments on each pipe_done. On wrap (every 4th pipe), period decrements by 1, floored at MIN_PERIOD. period and the pipe counter reset to SHIFT_PERIOD and 0 on reset and on every start.
- Undefined: period is constant SHIFT_PERIOD. No speed-up register exists.

Decomposition:
- Package pipe_sched_pkg: state enum (IDLE, SPACE, PIPE, FROZEN), LFSR seed 8'hA5, LFSR tap mask constant.
- Sub-module pipe_lfsr: 8-bit free-running LFSR with async active-low reset. Output is the current value.
- Divider, FSM and pattern generation stay in pipe_scheduler.

Test Plan:
All scenarios use ROWS=8, SHIFT_PERIOD=4, SPACE=3, PIPE_W=1, GAP_H=3, MIN_PERIOD=2.
1. Hold reset low mid-run, then release. Hold start=0 for 20 clk -> all outputs 0 throughout; no shift.
2. Pulse start -> shift on the 4th clk and every 4th clk after. col_pattern=8'h00 for shifts 1-3. Shift 4 carries the pipe pattern with pipe_done=1. Shifts 5-7 carry 8'h00.
3. Check every pipe column across 50 pipes -> each value is one of 8'b1111_0001, 8'b1110_0011, 8'b1100_0111, 8'b1000_1111, and matches the LFSR reference model.
4. Assert lose in the same cycle tick==1 -> shift=0 and pipe_done=0. running=0 next cycle. No shift for 20 clk. col_pattern unchanged.
5. From FROZEN, pulse start with lose=0 -> running=1. First shift 4 clk later with col_pattern=8'h00, i.e. the spacing restarts. Assert reset mid-PIPE -> outputs clear asynchronously, before the next clk edge.
6. PIPE_SCHED_SPEEDUP_EN defined -> after 4th pipe_done, shift spacing is 3 clk. After 8th it is 2 clk. After 12th it stays 2 clk. With the macro undefined, spacing stays 4.
